ddr4_init_sequencer: RTL
========================

// Module: ddr4_init_sequencer
// PURPOSE
//  Drives the DDR4 power-up/initialization command stream onto DDR_INTERFACE (reset_n, cke, cs_n,
//  act_n, ras_n_a16, cas_n_a15, we_n_a14, bg, ba, addr) ahead of the controller's normal traffic.
//  Sequence: RESET_n low -> CKE low -> tXPR -> 7 MRS writes -> tMOD -> ZQCL -> tZQinit -> init_done.
//  Its output is exactly what the interface protocol checker monitors (reset/CKE/tXPR-to-MRS properties).
// PARAMETERS
//  T_RESET_L  200   cycles reset_n held low after start accepted
//  T_CKE_L    500   cycles from reset_n rise to cke rise
//  T_XPR      10    cycles from cke rise to first MRS
//  T_MRD      8     cycles MRS-to-MRS
//  T_MOD      24    cycles last MRS to ZQCL
//  T_ZQINIT   1024  cycles ZQCL to init_done
//  MR_TABLE   126'h0 packed 7x18-bit MR values; slot i = MRi, bits[18*i+17:18*i] = {bg0,ba[1:0]... unused,A13:A0} (only [13:0] used)
// PORTS
//  clock_t    in   1   interface clock; all logic on posedge
//  reset      in   1   synchronous, active-high block reset
//  start      in   1   begin sequence; sampled in IDLE or DONE only
//  reset_n    out  1   DRAM RESET_n
//  cke        out  1   clock enable
//  cs_n       out  1   chip select
//  act_n      out  1   activate
//  ras_n_a16  out  1   RAS_n/A16
//  cas_n_a15  out  1   CAS_n/A15
//  we_n_a14   out  1   WE_n/A14
//  bg         out  2   bank group (MRS: bg[0]=MR# bit2, bg[1]=0)
//  ba         out  2   bank address (MRS: MR# bits1:0)
//  addr       out  14  A13:A0 (MRS: MR value; ZQCL: A10=1, rest 0)
//  busy       out  1   sequence in progress
//  init_done  out  1   high from end of tZQinit until next start or reset
// BEHAVIOUR
//  Reset values (and IDLE values): reset_n=0 cke=0 cs_n=1 act_n=1 ras/cas/we=1 bg=0 ba=0 addr=0 busy=0 init_done=0.
//  All outputs registered. Command bus is DES (cs_n=1, act_n/ras/cas/we=1, bg/ba/addr=0) on every cycle
//  except exactly one-cycle MRS or ZQCL slots.
//  MRS = cs_n0 act_n1 ras0 cas0 we0; ZQCL = cs_n0 act_n1 ras1 cas1 we0, A10=1.
//  States: IDLE, RST_LOW, CKE_LOW, XPR_WAIT, MRS_CMD, MRD_WAIT, MOD_WAIT, ZQCL_CMD, ZQ_WAIT, DONE.
//  One down-counter, width $clog2(max timing param)+1, reloaded on each state entry.
//  Timing, relative to edge E0 where start=1 is sampled:
//   busy=1 after E0; reset_n=1 after edge E0+T_RESET_L; cke=1 after edge Ec=E0+T_RESET_L+T_CKE_L.
//   MRS k (k=0..6) visible after edge Ec+T_XPR+k*T_MRD; MR order MR3,MR6,MR5,MR4,MR2,MR1,MR0.
//   ZQCL after edge Em+T_MOD (Em = MR0 edge); init_done=1, busy=0 after edge ZQCL+T_ZQINIT (state DONE).
//  cke stays 1 and reset_n stays 1 from their rise through DONE.
//  start while busy: ignored. start in DONE: init_done drops, full sequence restarts from RST_LOW,
//   reset_n driven low on next edge.
//  reset asserted at any state: next edge forces IDLE and reset values; no partial command completes.
//  Timing params must be >=1; T_MRD>=1 allows back-to-back DES gaps of T_MRD-1 cycles.
// TESTING (params T_RESET_L=4 T_CKE_L=6 T_XPR=5 T_MRD=3 T_MOD=4 T_ZQINIT=8)
//  Reset release, no start, 50 cycles -> all outputs hold reset values, bus DES.
//  start at edge 0 -> reset_n rises after edge 4, cke after edge 10; busy=1 from edge 0.
//  Same run -> MRS at edges 15,18,21,24,27,30,33 with {bg0,ba}=3,6,5,4,2,1,0 and addr=MR_TABLE slot.
//  Same run -> ZQCL (addr=14'h0400) after edge 37; init_done=1, busy=0 after edge 45; checker asserts pass.
//  reset pulsed at edge 20 (mid-MRS) -> edge 21 all reset values, no further MRS; new start replays full timeline.
//  start re-pulsed at edge 25 (busy) -> ignored, timeline unchanged; start in DONE -> init_done=0, reset_n=0 next edge.

Source files
------------

// File: rtl/ddr4_init_sequencer.sv
// DDR4 power-up / initialization sequencer.
// Sequence: RESET_n low, CKE low, tXPR, seven MRS writes (MR3,6,5,4,2,1,0), tMOD, ZQCL, tZQinit.
// Every output is a register loaded from the next-state decode, so each command slot is exactly
// one cycle wide. The bus idles at DES in every other cycle.
module ddr4_init_sequencer #(
    parameter int unsigned T_RESET_L = 200,
    parameter int unsigned T_CKE_L   = 500,
    parameter int unsigned T_XPR     = 10,
    parameter int unsigned T_MRD     = 8,
    parameter int unsigned T_MOD     = 24,
    parameter int unsigned T_ZQINIT  = 1024,
    parameter logic [125:0] MR_TABLE = '0
) (
    input  logic        clock_t_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        reset_n_o,
    output logic        cke_o,
    output logic        cs_n_o,
    output logic        act_n_o,
    output logic        ras_n_a16_o,
    output logic        cas_n_a15_o,
    output logic        we_n_a14_o,
    output logic [1:0]  bg_o,
    output logic [1:0]  ba_o,
    output logic [13:0] addr_o,
    output logic        busy_o,
    output logic        init_done_o
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TMax = max2(max2(max2(T_RESET_L, T_CKE_L), max2(T_XPR, T_MRD)),
                                        max2(T_MOD, T_ZQINIT));
    localparam int unsigned CntW = $clog2(TMax) + 1;

    // A state lasting T cycles loads T-1; the one-cycle command slot is taken out of the waits.
    localparam logic [CntW-1:0] RstLoad = CntW'(T_RESET_L - 1);
    localparam logic [CntW-1:0] CkeLoad = CntW'(T_CKE_L - 1);
    localparam logic [CntW-1:0] XprLoad = CntW'(T_XPR - 1);
    localparam logic [CntW-1:0] MrdLoad = CntW'((T_MRD > 1) ? T_MRD - 2 : 0);
    localparam logic [CntW-1:0] ModLoad = CntW'((T_MOD > 1) ? T_MOD - 2 : 0);
    localparam logic [CntW-1:0] ZqLoad  = CntW'((T_ZQINIT > 1) ? T_ZQINIT - 2 : 0);

    // Command encodings {cs_n, act_n, ras_n, cas_n, we_n}
    localparam logic [4:0] CmdDes  = 5'b11111;
    localparam logic [4:0] CmdMrs  = 5'b01000;
    localparam logic [4:0] CmdZqcl = 5'b01110;

    typedef enum logic [3:0] {
        StIdle, StRstLow, StCkeLow, StXprWait, StMrsCmd,
        StMrdWait, StModWait, StZqclCmd, StZqWait, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;

    logic        reset_n_d, cke_d, busy_d, done_d;
    logic [4:0]  cmd_d, cmd_q;
    logic [1:0]  bg_d, ba_d, bg_q, ba_q;
    logic [13:0] addr_d, addr_q;
    logic        reset_n_q, cke_q, busy_q, done_q;
    logic [2:0]  mr_num;

    // MRS issue order: slot k of the sequence writes this mode register
    always_comb begin
        mr_num = 3'd0;
        unique case (idx_d)
            3'd0:    mr_num = 3'd3;
            3'd1:    mr_num = 3'd6;
            3'd2:    mr_num = 3'd5;
            3'd3:    mr_num = 3'd4;
            3'd4:    mr_num = 3'd2;
            3'd5:    mr_num = 3'd1;
            default: mr_num = 3'd0;
        endcase
    end

    // Next state, interval counter and MRS index
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StRstLow;
            StRstLow:  if (cnt_q == '0) state_d = StCkeLow;
            StCkeLow:  if (cnt_q == '0) state_d = StXprWait;
            StXprWait: if (cnt_q == '0) state_d = StMrsCmd;
            StMrsCmd: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd6) state_d = (T_MOD > 1) ? StModWait : StZqclCmd;
                else               state_d = (T_MRD > 1) ? StMrdWait : StMrsCmd;
            end
            StMrdWait: if (cnt_q == '0) state_d = StMrsCmd;
            StModWait: if (cnt_q == '0) state_d = StZqclCmd;
            StZqclCmd: state_d = (T_ZQINIT > 1) ? StZqWait : StDone;
            StZqWait:  if (cnt_q == '0) state_d = StDone;
            StDone:    if (start_i) state_d = StRstLow;
            default:   state_d = StIdle;
        endcase
        if (state_d != state_q) begin
            unique case (state_d)
                StRstLow:  cnt_d = RstLoad;
                StCkeLow:  cnt_d = CkeLoad;
                StXprWait: cnt_d = XprLoad;
                StMrdWait: cnt_d = MrdLoad;
                StModWait: cnt_d = ModLoad;
                StZqWait:  cnt_d = ZqLoad;
                default:   cnt_d = '0;
            endcase
        end
        if (state_d == StRstLow) idx_d = 3'd0;
    end

    // Output decode from the next state so the registered pins line up with state entry
    always_comb begin
        reset_n_d = 1'b1;
        cke_d     = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        cmd_d     = CmdDes;
        bg_d      = 2'b00;
        ba_d      = 2'b00;
        addr_d    = 14'h0;
        unique case (state_d)
            StIdle: begin
                reset_n_d = 1'b0;
                cke_d     = 1'b0;
                busy_d    = 1'b0;
            end
            StRstLow: begin
                reset_n_d = 1'b0;
                cke_d     = 1'b0;
            end
            StCkeLow: cke_d = 1'b0;
            StMrsCmd: begin
                cmd_d  = CmdMrs;
                bg_d   = {1'b0, mr_num[2]};
                ba_d   = mr_num[1:0];
                addr_d = MR_TABLE[18*int'(mr_num) +: 14];
            end
            StZqclCmd: begin
                cmd_d  = CmdZqcl;
                addr_d = 14'h0400;
            end
            StDone: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any command in flight
    always_ff @(posedge clock_t_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            reset_n_q <= 1'b0;
            cke_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cmd_q     <= CmdDes;
            bg_q      <= 2'b00;
            ba_q      <= 2'b00;
            addr_q    <= 14'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            reset_n_q <= reset_n_d;
            cke_q     <= cke_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cmd_q     <= cmd_d;
            bg_q      <= bg_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
        end
    end

    assign reset_n_o   = reset_n_q;
    assign cke_o       = cke_q;
    assign busy_o      = busy_q;
    assign init_done_o = done_q;
    assign cs_n_o      = cmd_q[4];
    assign act_n_o     = cmd_q[3];
    assign ras_n_a16_o = cmd_q[2];
    assign cas_n_a15_o = cmd_q[1];
    assign we_n_a14_o  = cmd_q[0];
    assign bg_o        = bg_q;
    assign ba_o        = ba_q;
    assign addr_o      = addr_q;

endmodule
